sparkle_scheduler: RTL
======================

Name: sparkle_scheduler

Overview:
- Shares one 4-frame, 20x20 sparkle sprite ROM among NUM_SLOTS on-screen sparkle instances.
- Each pixel clock it picks the highest-priority enabled slot whose 20x20 window contains the current VGA (row, col) and emits the ROM address for that pixel.
- Per-slot animation counters run continuously. The frame index each slot displays changes only at frame_start, so sprites never tear mid-screen.
- Sits between the VGA timing/position logic and the sparkle ROM; its outputs feed the pixel mux.

Parameters:
- NUM_SLOTS, 8, number of sparkle instances (1..8).
- SPRITE_DIM, 20, sprite width and height in pixels.
- FRAME_WORDS, 400, ROM words per animation frame (SPRITE_DIM*SPRITE_DIM).
- NUM_FRAMES, 4, animation frames stored in ROM.
- TICK_PERIOD, 5000, clocks per animation step at rate select 0; rate select 1 uses 3*TICK_PERIOD.

Ports:
- clk  in  1  pixel clock
- reset  in  1  asynchronous, active-high
- row  in  9  current scan row
- col  in  10  current scan column
- frame_start  in  1  one-cycle pulse at start of vertical frame
- slot_en  in  NUM_SLOTS  per-slot enable
- slot_row  in  9*NUM_SLOTS  packed origin rows; slot i occupies bits [9i+8:9i]
- slot_col  in  10*NUM_SLOTS  packed origin columns; slot i occupies bits [10i+9:10i]
- slot_rev  in  NUM_SLOTS  1 = animate frames in descending order
- slot_slow  in  NUM_SLOTS  1 = use 3*TICK_PERIOD
- rom_addr  out  12  sprite ROM address
- hit  out  1  rom_addr is valid for this pixel
- hit_slot  out  3  index of the winning slot

Behaviour:
- Reset clears all of the following, with hit_slot and rom_addr held at 0 while reset is high:
  - all tick counters
  - all live frame indices
  - all displayed frame indices
  - rom_addr, hit, hit_slot
- Window test for slot i: row >= r_i, row < r_i+SPRITE_DIM, col >= c_i, col < c_i+SPRITE_DIM.
  - The comparisons are evaluated at 11-bit width, so an origin near the screen edge must not wrap. Example: r_i = 500 covers rows 500..511 only.
- Arbitration is fixed priority: the lowest-index enabled slot that hits wins. There is no fairness requirement because overlap is purely visual.
- Address: rom_addr = disp_frame[w]*FRAME_WORDS + (row-r_w)*SPRITE_DIM + (col-c_w).
  - The address is computed from the pixel position. There is no running address counter.
  - Computation is done at 12-bit width, and the maximum address is 1599.
- Latency: rom_addr, hit and hit_slot are registered, exactly 1 clock after the (row, col) sample.
  - With no hit: hit=0, rom_addr holds its previous value, and hit_slot=0.
- Tick counter per slot, each clock while slot_en[i]=1:
  - If tick_i equals its period minus 1: set tick_i to 0 and step live_frame_i.
  - Otherwise increment tick_i.
  - Step direction: forward is (f+1) mod NUM_FRAMES; reverse (slot_rev[i]=1) is (f-1) mod NUM_FRAMES, so 0 goes to NUM_FRAMES-1.
- slot_en[i]=0 forces tick_i=0, live_frame_i=0 and disp_frame_i=0 on the next clock. Re-enabling starts from frame 0.
- On frame_start, disp_frame_i <= live_frame_i for all slots simultaneously.
  - If a step and frame_start occur in the same cycle, disp_frame receives the pre-step (old) live value.
- Changing slot_rev or slot_slow mid-animation takes effect at the next tick evaluation. The current tick count is kept; if it is already at or above the new period, the counter wraps and steps on the next clock.
- Changing an origin mid-frame takes effect on the next pixel. No buffering is required.

Decomposition:
- Shared package sparkle_pkg holds:
  - SPRITE_DIM, FRAME_WORDS, NUM_FRAMES, ROM_AW=12
  - the frame-step function
- One sub-module: sparkle_anim_slot, per-slot tick counter, live frame and displayed frame, instantiated NUM_SLOTS times.
- The top level keeps the window compare, priority encode and address arithmetic.

Test Plan:
- Single slot 0 at (140,20), enabled; scan row 145, col 27 -> one clock later hit=1, hit_slot=0, rom_addr=0*400+5*20+7=107.
- Overlap: slot 1 at (100,100) and slot 3 at (110,110) both enabled; pixel (115,115) -> hit_slot=1, rom_addr=15*20+15=315.
- Animation with TICK_PERIOD overridden to 4:
  - Forward slot pulsing frame_start every 4 clocks -> disp_frame sequence 0,1,2,3,0.
  - slot_rev=1 -> sequence 0,3,2,1.
  - slot_slow=1 -> steps every 12 clocks.
- Tear protection: a live step occurs without frame_start -> rom_addr still uses the old frame. After frame_start, the same pixel moves up by 400 (e.g. 107 -> 507).
- Edge window: slot at (500,630); pixel (511,639) -> hit=1, addr=11*20+9=229. Pixel (0,0) -> hit=0.
- Reset and disable:
  - Assert reset mid-animation -> all outputs 0 immediately (asynchronous).
  - Deassert reset, then drop slot_en[0] for 1 clock -> its disp_frame returns to 0.

Source files
------------

// File: rtl/sparkle_pkg.sv
// Shared constants and helpers for the sparkle sprite scheduler.
// The sprite ROM holds NUM_FRAMES frames of SPRITE_DIM x SPRITE_DIM words.
package sparkle_pkg;

    localparam int SPRITE_DIM  = 20;
    localparam int FRAME_WORDS = SPRITE_DIM * SPRITE_DIM;
    localparam int NUM_FRAMES  = 4;
    localparam int ROM_AW      = 12;
    localparam int FRAME_W     = 2;

    typedef logic [FRAME_W-1:0] frame_t;

    // Advance an animation frame index one step, wrapping in either direction.
    function automatic frame_t step_frame(input frame_t f, input logic rev);
        frame_t nxt;
        if (rev)
            nxt = (f == frame_t'(0)) ? frame_t'(NUM_FRAMES - 1) : f - frame_t'(1);
        else
            nxt = (f == frame_t'(NUM_FRAMES - 1)) ? frame_t'(0) : f + frame_t'(1);
        return nxt;
    endfunction

endpackage

// File: rtl/sparkle_scheduler_if.sv
// Pixel-position inputs and ROM-address outputs of the sparkle scheduler.
// The VGA timing side is the master; the scheduler is the slave.
interface sparkle_scheduler_if;
    import sparkle_pkg::*;

    logic [8:0]        row;
    logic [9:0]        col;
    logic              frame_start;
    logic [ROM_AW-1:0] rom_addr;
    logic              hit;
    logic [2:0]        hit_slot;

    modport master (
        output row, col, frame_start,
        input  rom_addr, hit, hit_slot
    );

    modport slave (
        input  row, col, frame_start,
        output rom_addr, hit, hit_slot
    );

endinterface

// File: rtl/sparkle_anim_slot.sv
// Per-slot animation state: free-running tick counter, live frame index,
// and the displayed frame index that only follows live at frame_start.
module sparkle_anim_slot
    import sparkle_pkg::*;
#(
    parameter int TICK_PERIOD = 5000
) (
    input  logic   clk,
    input  logic   reset,
    input  logic   en,
    input  logic   rev,
    input  logic   slow,
    input  logic   frame_start,
    output frame_t disp_frame
);

    localparam int SLOW_PERIOD = 3 * TICK_PERIOD;
    localparam int TW          = $clog2(SLOW_PERIOD + 1);

    logic [TW-1:0] tick;
    logic [TW-1:0] tick_max;
    frame_t        live_frame;

    assign tick_max = slow ? TW'(SLOW_PERIOD - 1) : TW'(TICK_PERIOD - 1);

    // Comparing with >= lets a rate change below the current count wrap at once.
    // disp_frame samples live_frame before this cycle's step, so it gets the old value.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tick       <= '0;
            live_frame <= '0;
            disp_frame <= '0;
        end else if (!en) begin
            tick       <= '0;
            live_frame <= '0;
            disp_frame <= '0;
        end else begin
            if (tick >= tick_max) begin
                tick       <= '0;
                live_frame <= step_frame(live_frame, rev);
            end else begin
                tick <= tick + TW'(1);
            end
            if (frame_start)
                disp_frame <= live_frame;
        end
    end

endmodule

// File: rtl/sparkle_scheduler.sv
// Shares one sparkle sprite ROM among NUM_SLOTS on-screen instances: window
// compare, fixed-priority pick, and registered ROM address per pixel.
module sparkle_scheduler
    import sparkle_pkg::*;
#(
    parameter int NUM_SLOTS   = 8,
    parameter int TICK_PERIOD = 5000
) (
    input  logic                    clk,
    input  logic                    reset,
    sparkle_scheduler_if.slave      pix,
    input  logic [NUM_SLOTS-1:0]    slot_en,
    input  logic [9*NUM_SLOTS-1:0]  slot_row,
    input  logic [10*NUM_SLOTS-1:0] slot_col,
    input  logic [NUM_SLOTS-1:0]    slot_rev,
    input  logic [NUM_SLOTS-1:0]    slot_slow
);

    logic [10:0]          row_w;
    logic [10:0]          col_w;
    logic [10:0]          org_row [NUM_SLOTS];
    logic [10:0]          org_col [NUM_SLOTS];
    frame_t               disp_frame [NUM_SLOTS];
    logic [NUM_SLOTS-1:0] in_win;

    logic                 any_hit;
    logic [2:0]           win;
    logic [10:0]          win_row;
    logic [10:0]          win_col;
    frame_t               win_frame;
    logic [ROM_AW-1:0]    next_addr;

    // Widened to 11 bits so a window near the bottom/right edge cannot wrap.
    assign row_w = {2'b00, pix.row};
    assign col_w = {1'b0, pix.col};

    for (genvar i = 0; i < NUM_SLOTS; i++) begin : g_slot
        assign org_row[i] = {2'b00, slot_row[9*i +: 9]};
        assign org_col[i] = {1'b0, slot_col[10*i +: 10]};
        assign in_win[i]  = slot_en[i]
                          && (row_w >= org_row[i]) && (row_w < org_row[i] + 11'(SPRITE_DIM))
                          && (col_w >= org_col[i]) && (col_w < org_col[i] + 11'(SPRITE_DIM));

        sparkle_anim_slot #(
            .TICK_PERIOD (TICK_PERIOD)
        ) u_anim (
            .clk         (clk),
            .reset       (reset),
            .en          (slot_en[i]),
            .rev         (slot_rev[i]),
            .slow        (slot_slow[i]),
            .frame_start (pix.frame_start),
            .disp_frame  (disp_frame[i])
        );
    end

    // Scan from the highest index down so the lowest-index hit is written last.
    always_comb begin
        any_hit   = 1'b0;
        win       = '0;
        win_row   = '0;
        win_col   = '0;
        win_frame = '0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (in_win[i]) begin
                any_hit   = 1'b1;
                win       = 3'(i);
                win_row   = row_w - org_row[i];
                win_col   = col_w - org_col[i];
                win_frame = disp_frame[i];
            end
        end
    end

    assign next_addr = ROM_AW'(win_frame) * ROM_AW'(FRAME_WORDS)
                     + ROM_AW'(win_row) * ROM_AW'(SPRITE_DIM)
                     + ROM_AW'(win_col);

    // On a miss rom_addr keeps its last value; hit_slot falls back to 0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pix.rom_addr <= '0;
            pix.hit      <= 1'b0;
            pix.hit_slot <= '0;
        end else begin
            pix.hit      <= any_hit;
            pix.hit_slot <= win;
            if (any_hit)
                pix.rom_addr <= next_addr;
        end
    end

endmodule
